game_controller: RTL

Round sequencer for the Frogger board. Owns the game state machine (idle, play, win/lose display hold, game over) and consumes the per-cycle win/lose flags from the collision/result checker. Drives the frog-position reset, the lane-scroll tick whose rate rises with level, and the lives/level/score counters shown on the board. Sits between the key inputs and the pixel/lane logic.

---
 rtl/game_pkg.sv | 15 +
 rtl/scroll_timer.sv | 33 +++
 rtl/game_controller.sv | 126 ++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared round-state encoding and constants for the Frogger board
package game_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PLAY,
    WIN_HOLD,
    LOSE_HOLD,
    OVER
  } state_t;

  localparam int GUARD_CYCLES = 2;
  localparam int SCORE_MAX    = 255;

endpackage

// File: rtl/scroll_timer.sv
// rtl/scroll_timer.sv - lane-scroll period counter with a one-cycle terminal-count pulse
module scroll_timer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        enable,
  input  logic [31:0] period,
  output logic        tick
);

  logic [31:0] count;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= 32'd0;
      tick  <= 1'b0;
    end else if (clear) begin
      count <= 32'd0;
      tick  <= 1'b0;
    end else if (enable) begin
      if (count == period - 32'd1) begin
        count <= 32'd0;
        tick  <= 1'b1;
      end else begin
        count <= count + 32'd1;
        tick  <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/game_controller.sv
// rtl/game_controller.sv - Frogger round sequencer: state machine, hold/guard timing, lives/level/score
module game_controller
  import game_pkg::*;
#(
  parameter int unsigned LIVES       = 3,
  parameter int unsigned MAX_LEVEL   = 7,
  parameter int unsigned HOLD_CYCLES = 50_000_000,
  parameter int unsigned BASE_PERIOD = 25_000_000,
  parameter int unsigned STEP        = 3_000_000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  input  logic       win_in,
  input  logic       lose_in,
  output logic       frog_reset,
  output logic       scroll_tick,
  output logic [2:0] level,
  output logic [1:0] lives,
  output logic [7:0] score,
  output logic       show_win,
  output logic       show_lose,
  output logic       game_over
);

  localparam logic [1:0] GUARD     = 2'(GUARD_CYCLES);
  localparam logic [2:0] LEVEL_TOP = 3'(MAX_LEVEL);
  localparam logic [7:0] SCORE_TOP = 8'(SCORE_MAX);
  localparam logic [1:0] LIVES_INI = 2'(LIVES);

  state_t      state, nextState;
  logic        startQ, winQ, loseQ;
  logic [1:0]  guardCnt;
  logic [31:0] holdCnt;
  logic [1:0]  nextLives;
  logic [2:0]  nextLevel;
  logic [7:0]  nextScore;
  logic        startEdge, canSample, enterPlay, holdDone, timerEnable;
  logic [31:0] period;

  assign startEdge   = start & ~startQ;
  assign canSample   = (state == PLAY) && (guardCnt == GUARD);
  assign holdDone    = (holdCnt == HOLD_CYCLES - 32'd1);
  assign enterPlay   = (nextState == PLAY) && (state != PLAY);
  assign timerEnable = (state == PLAY) && (nextState == PLAY);
  assign period      = 32'(BASE_PERIOD) - 32'(level) * 32'(STEP);

  always_comb begin
    nextState = state;
    nextLives = lives;
    nextLevel = level;
    nextScore = score;
    case (state)
      IDLE: begin
        if (startEdge) nextState = PLAY;
      end
      PLAY: begin
        // winQ/loseQ only ever capture post-guard samples, so no guard test here
        if (loseQ) begin
          nextLives = lives - 2'd1;
          nextState = (lives == 2'd1) ? OVER : LOSE_HOLD;
        end else if (winQ) begin
          nextLevel = (level == LEVEL_TOP) ? level : level + 3'd1;
          nextScore = (score == SCORE_TOP) ? score : score + 8'd1;
          nextState = WIN_HOLD;
        end
      end
      WIN_HOLD, LOSE_HOLD: begin
        if (holdDone) nextState = PLAY;
      end
      OVER: begin
        if (startEdge) begin
          nextLives = LIVES_INI;
          nextLevel = 3'd0;
          nextScore = 8'd0;
          nextState = PLAY;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      startQ     <= 1'b0;
      winQ       <= 1'b0;
      loseQ      <= 1'b0;
      guardCnt   <= 2'd0;
      holdCnt    <= 32'd0;
      lives      <= LIVES_INI;
      level      <= 3'd0;
      score      <= 8'd0;
      frog_reset <= 1'b0;
      show_win   <= 1'b0;
      show_lose  <= 1'b0;
      game_over  <= 1'b0;
    end else begin
      state      <= nextState;
      startQ     <= start;
      winQ       <= win_in & canSample;
      loseQ      <= lose_in & canSample;
      lives      <= nextLives;
      level      <= nextLevel;
      score      <= nextScore;
      frog_reset <= enterPlay;
      show_win   <= (nextState == WIN_HOLD);
      show_lose  <= (nextState == LOSE_HOLD);
      game_over  <= (nextState == OVER);
      if (enterPlay) guardCnt <= 2'd0;
      else if (state == PLAY && guardCnt != GUARD) guardCnt <= guardCnt + 2'd1;
      holdCnt <= ((state == WIN_HOLD || state == LOSE_HOLD) && nextState == state)
                 ? holdCnt + 32'd1 : 32'd0;
    end
  end

  scroll_timer u_scroll_timer (
    .clk    (clk),
    .reset_n(reset_n),
    .clear  (enterPlay),
    .enable (timerEnable),
    .period (period),
    .tick   (scroll_tick)
  );

endmodule
